// File: rtl/icg_ctrl.sv
// Idle-based clock-gate sequencer: drives one shared gate-cell enable from N requesters plus busy.
// Optional gated-cycle statistics counter is built when ICG_CTRL_STATS_EN is defined.
module icg_ctrl #(
  parameter int N_REQ       = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  input  logic             busy,
  input  logic             force_on,
  output logic             icg_en,
  output logic             gated,
  input  logic             stats_clr,
  output logic [31:0]      gated_cycles
);

  typedef enum logic [1:0] {
    S_ON    = 2'd0,
    S_COUNT = 2'd1,
    S_OFF   = 2'd2,
    S_WAKE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_icg_en;
  logic             r_gated;
  logic [N_REQ-1:0] r_ack;
  logic             w_active;
  logic             w_clk_running;

  assign w_active      = (|req) | busy | force_on;
  assign w_clk_running = (r_state == S_ON) || (r_state == S_COUNT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_ON;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // WAKE ignores activity on purpose: once the enable rises the gate must settle before any ack.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_ON: begin
        if (!w_active) begin
          w_state_nxt = S_COUNT;
          w_cnt_nxt   = '0;
        end
      end
      S_COUNT: begin
        if (w_active) begin
          w_state_nxt = S_ON;
        end else if (r_cnt == IDLE_LAST) begin
          w_state_nxt = S_OFF;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_OFF: begin
        if (w_active) begin
          w_state_nxt = S_WAKE;
          w_cnt_nxt   = '0;
        end
      end
      S_WAKE: begin
        if (r_cnt == WAKE_LAST) begin
          w_state_nxt = S_ON;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_ON;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Enable and status are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_icg_en <= 1'b1;
      r_gated  <= 1'b0;
      r_ack    <= '0;
    end else begin
      r_icg_en <= (w_state_nxt != S_OFF);
      r_gated  <= (w_state_nxt == S_OFF);
      r_ack    <= w_clk_running ? req : '0;
    end
  end

  assign icg_en = r_icg_en;
  assign gated  = r_gated;
  assign ack    = r_ack;

`ifdef ICG_CTRL_STATS_EN
  logic [31:0] r_gated_cycles;

  // Clear beats increment; the counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gated_cycles <= '0;
    end else if (stats_clr) begin
      r_gated_cycles <= '0;
    end else if (r_gated && (r_gated_cycles != 32'hFFFF_FFFF)) begin
      r_gated_cycles <= r_gated_cycles + 32'd1;
    end
  end

  assign gated_cycles = r_gated_cycles;
`else
  logic w_unused_stats_clr;

  assign w_unused_stats_clr = stats_clr;
  assign gated_cycles       = '0;
`endif

endmodule

// File: doc/icg_ctrl.md
Name: icg_ctrl

Overview:
- Idle-based clock-gate sequencer. Drives the enable of one shared gated-clock cell from N requesters plus a datapath busy flag.
- Turns the gated clock off after a programmable idle window. Restores it on demand and acknowledges requesters only once the gated clock is guaranteed running.
- Sits in the always-on clock domain (ungated clk), next to the gate cell it controls.

Parameters:
- N_REQ, 4, number of requester ports.
- IDLE_CYCLES, 16, consecutive idle cycles before gating. Legal range 1..255.
- WAKE_CYCLES, 2, cycles between enable rise and first ack. Covers gate latch plus enable-sync latency. Legal range 1..255.
- CNT_W, 8, internal counter width. Must hold max(IDLE_CYCLES, WAKE_CYCLES).

Ports:
- clk  in  1  free-running clock; same clock fed to the gate cell.
- rstn  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester clock request; level; held until ack seen.
- ack  out  N_REQ  per-requester grant: gated clock running.
- busy  in  1  datapath activity; keeps clock on, no ack.
- force_on  in  1  debug/CSR override; holds clock on.
- icg_en  out  1  enable to gate cell.
- gated  out  1  status, 1 while state OFF.
- stats_clr  in  1  clears statistics counter (optional feature).
- gated_cycles  out  32  statistics counter (optional feature).

Behaviour:
- Active = (|req) | busy | force_on. All outputs registered. The state machine runs on clk, never on the gated clock.
- Reset, asynchronous on rstn low: state=ON, icg_en=1, gated=0, ack=0, cnt=0, gated_cycles=0. Clock runs out of reset.
- ON (icg_en=1): if !active, go to COUNT with cnt=0; otherwise stay.
- COUNT (icg_en=1):
  - if active, go to ON; activity wins over expiry on the same cycle.
  - else if cnt==IDLE_CYCLES-1, go to OFF; icg_en=0 and gated=1 from the next cycle.
  - else cnt++.
  - With IDLE_CYCLES=1: the first idle cycle enters COUNT, and OFF follows one cycle later.
- OFF (icg_en=0, gated=1): if active, go to WAKE with cnt=0; icg_en=1 and gated=0 on the next cycle.
- WAKE (icg_en=1): if cnt==WAKE_CYCLES-1, go to ON; else cnt++.
  - Not abortable: if activity drops mid-wake, WAKE still completes to ON, then idle counting restarts normally.
- ack[i]:
  - Registered: ack[i] <= req[i] & (state in {ON, COUNT}).
  - Never 1 while in OFF or WAKE.
  - Latency from req rise in ON/COUNT: 1 cycle.
  - Latency from OFF: 1 (to WAKE) + WAKE_CYCLES + 1 cycles.
  - Drops 1 cycle after req drops.
- Handshake: a requester holds req until it sees ack, then keeps req high for as long as it needs the clock. Dropping req before ack is legal; ack for that requester then never asserts.
- Simultaneous requests: all requesters present in ON/COUNT are acked on the same cycle. There is no arbitration; the clock is a shared, non-exclusive resource.
- force_on=1: forces exit from OFF via WAKE and pins ON; ack still follows req.
- Reset mid-WAKE or mid-COUNT: immediately ON, icg_en=1, ack=0.
- cnt width: CNT_W bits, never wraps; it is bounded by the compare.

Optional Feature:
- ICG_CTRL_STATS_EN defined:
  - gated_cycles increments on every cycle with gated=1. It saturates at 32'hFFFF_FFFF, with no wrap.
  - stats_clr=1 zeroes it on the next cycle; clear wins over increment.
- Not defined: counter logic is absent, gated_cycles is tied 0, and stats_clr is ignored.

Test Plan:
- Reset release, all inputs 0, IDLE_CYCLES=16 -> icg_en stays 1 for 17 cycles (ON, then 16 COUNT cycles), drops on cycle 18; gated=1 from that cycle.
- From OFF, req[2]=1 at cycle T, WAKE_CYCLES=2 -> icg_en=1 at T+1, ack[2]=1 at T+4, ack[0,1,3]=0.
- In COUNT with cnt=15, busy pulse coincident with expiry -> stays ON, icg_en never drops; ack stays 0.
- req[0] and req[3] high together in ON -> both acks 1 the next cycle; drop req[0] -> ack[0]=0 one cycle later, ack[3] holds, no gating.
- Assert rstn=0 two cycles into WAKE, release -> icg_en=1, ack=0 immediately; idle gating restarts from ON.
- With ICG_CTRL_STATS_EN: gate for 100 cycles -> gated_cycles=100; stats_clr on the same cycle as an increment -> 0. Preload near max -> holds at 32'hFFFF_FFFF.
